// File: rtl/typhoon_pkg.sv
// Shared types and default geometry for the tiled render pipeline.
package typhoon_pkg;

    localparam int unsigned COORD_W      = 10;
    localparam int unsigned DEF_TILE_DIM = 8;
    localparam int unsigned DEF_SCREEN_W = 640;
    localparam int unsigned DEF_SCREEN_H = 480;

    typedef logic [COORD_W-1:0] coord_t;

    // Tile descriptor handed to a unit with its start pulse.
    typedef struct packed {
        coord_t x;
        coord_t y;
        logic   id;
    } tile_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_SWAP
    } sched_state_t;

endpackage

// File: rtl/tile_scheduler_if.sv
// Handshake and coordinate bundle between the tile scheduler and the
// rasterizer, framebuffer streamer and VGA path.
interface tile_scheduler_if;
    import typhoon_pkg::*;

    logic   frameStart;
    logic   autoRun;
    logic   vblank;

    logic   rasterStart;
    logic   rasterDone;
    logic   rasterTileID;
    coord_t rasterX;
    coord_t rasterY;

    logic   streamStart;
    logic   streamDone;
    logic   streamTileID;
    coord_t streamX;
    coord_t streamY;

    logic   bufferSelect;
    logic   frameDone;
    logic   busy;

    modport master (
        input  frameStart, autoRun, vblank, rasterDone, streamDone,
        output rasterStart, rasterTileID, rasterX, rasterY,
        output streamStart, streamTileID, streamX, streamY,
        output bufferSelect, frameDone, busy
    );

    modport slave (
        output frameStart, autoRun, vblank, rasterDone, streamDone,
        input  rasterStart, rasterTileID, rasterX, rasterY,
        input  streamStart, streamTileID, streamX, streamY,
        input  bufferSelect, frameDone, busy
    );

endinterface

// File: rtl/tile_scheduler_done_tracker.sv
// Per-unit pending flag: set by a start pulse, cleared by a rising edge of
// the unit's done level.
module done_tracker (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic done,
    output logic pending
);

    logic flag_q;
    logic done_prev_q;
    logic rise_c;

    assign rise_c = done & ~done_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_q      <= 1'b0;
            done_prev_q <= 1'b0;
        end else begin
            done_prev_q <= done;
            if (start) begin
                flag_q <= 1'b1;
            end else if (rise_c) begin
                flag_q <= 1'b0;
            end
        end
    end

    // Edge seen this cycle already counts as cleared so the scheduler can
    // issue the next start on the following cycle.
    assign pending = flag_q & ~rise_c;

endmodule

// File: rtl/tile_scheduler.sv
// Tile-by-tile frame sequencer: ping-pongs two tile buffers between the
// rasterizer and the framebuffer streamer, then flips the display buffer.
// Define TYPHOON_VSYNC_SWAP_EN to hold the buffer flip until vblank.
module tile_scheduler
    import typhoon_pkg::*;
#(
    parameter int unsigned TILE_DIM = DEF_TILE_DIM,
    parameter int unsigned SCREEN_W = DEF_SCREEN_W,
    parameter int unsigned SCREEN_H = DEF_SCREEN_H
) (
    input  logic             BOARD_CLK,
    input  logic             Reset,
    tile_scheduler_if.master bus
);

    localparam coord_t LAST_X = COORD_W'(SCREEN_W - TILE_DIM);
    localparam coord_t LAST_Y = COORD_W'(SCREEN_H - TILE_DIM);
    localparam coord_t STEP   = COORD_W'(TILE_DIM);

    sched_state_t state;
    tile_t        raster_q;
    tile_t        stream_q;
    logic         raster_start_q;
    logic         stream_start_q;
    logic         buf_sel_q;
    logic         frame_done_q;
    logic         busy_q;

    logic         raster_pending;
    logic         stream_pending;
    logic         go_c;
    logic         last_tile_c;
    logic         row_end_c;
    logic         issue_raster_c;
    logic         issue_stream_c;
    logic         swap_c;

`ifdef TYPHOON_VSYNC_SWAP_EN
    assign swap_c = bus.vblank;
`else
    logic vblank_unused;
    assign vblank_unused = bus.vblank;
    assign swap_c        = 1'b1;
`endif

    // Start-pulse decisions; also feed the pending trackers.
    always_comb begin
        issue_raster_c = 1'b0;
        issue_stream_c = 1'b0;
        go_c           = bus.frameStart | bus.autoRun;
        row_end_c      = (raster_q.x == LAST_X);
        last_tile_c    = row_end_c && (raster_q.y == LAST_Y);
        case (state)
            S_IDLE: begin
                issue_raster_c = go_c;
            end
            S_RUN: begin
                if (!raster_pending && !stream_pending) begin
                    issue_stream_c = 1'b1;
                    issue_raster_c = !last_tile_c;
                end
            end
            default: begin
            end
        endcase
    end

    done_tracker u_raster_trk (
        .clk     (BOARD_CLK),
        .rst     (Reset),
        .start   (issue_raster_c),
        .done    (bus.rasterDone),
        .pending (raster_pending)
    );

    done_tracker u_stream_trk (
        .clk     (BOARD_CLK),
        .rst     (Reset),
        .start   (issue_stream_c),
        .done    (bus.streamDone),
        .pending (stream_pending)
    );

    always_ff @(posedge BOARD_CLK or posedge Reset) begin
        if (Reset) begin
            state          <= S_IDLE;
            raster_q       <= '0;
            stream_q       <= '0;
            raster_start_q <= 1'b0;
            stream_start_q <= 1'b0;
            buf_sel_q      <= 1'b0;
            frame_done_q   <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            raster_start_q <= issue_raster_c;
            stream_start_q <= issue_stream_c;
            frame_done_q   <= 1'b0;
            case (state)
                S_IDLE: begin
                    busy_q <= go_c;
                    if (go_c) begin
                        raster_q <= '0;
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (issue_stream_c) begin
                        stream_q <= raster_q;
                        if (last_tile_c) begin
                            state <= S_DRAIN;
                        end else begin
                            raster_q.x  <= row_end_c ? '0 : raster_q.x + STEP;
                            raster_q.y  <= row_end_c ? raster_q.y + STEP : raster_q.y;
                            raster_q.id <= ~raster_q.id;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!stream_pending) begin
                        state <= S_SWAP;
                    end
                end
                S_SWAP: begin
                    if (swap_c) begin
                        buf_sel_q    <= ~buf_sel_q;
                        frame_done_q <= 1'b1;
                        state        <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rasterStart  = raster_start_q;
    assign bus.rasterTileID = raster_q.id;
    assign bus.rasterX      = raster_q.x;
    assign bus.rasterY      = raster_q.y;
    assign bus.streamStart  = stream_start_q;
    assign bus.streamTileID = stream_q.id;
    assign bus.streamX      = stream_q.x;
    assign bus.streamY      = stream_q.y;
    assign bus.bufferSelect = buf_sel_q;
    assign bus.frameDone    = frame_done_q;
    assign bus.busy         = busy_q;

endmodule
